// File: rtl/imem_loader.sv
// Purpose: boot loader that turns a byte stream (len_hi, len_lo, N x 4-byte BE words, xor checksum)
//          into instruction-memory word writes, holding the CPU in reset until a good image lands.
// Latency: imem_we pulses one cycle after the 4th byte of each word is accepted.
// Backpressure: rx_ready is a pure function of state (high while loading, low in DONE/ERR);
//               rx_valid may drop at any time and the loader simply waits.
// Ports: clock/reset (sync, active-high); rx_valid/rx_data/rx_ready byte stream in;
//        imem_we/imem_addr/imem_wdata memory write port; cpu_hold, done, error status.
module imem_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t      state;
    state_t      next_state;
    logic [1:0]  byte_cnt;
    logic [15:0] word_cnt;
    logic [15:0] n_words;
    logic [7:0]  csum;
    logic [31:0] asm_reg;

    logic        xfer;
    logic [15:0] len_full;
    logic        last_word;
    logic        word_end;

    assign xfer      = rx_valid && rx_ready;
    // Count as it stands once the low byte is on the bus.
    assign len_full  = {n_words[15:8], rx_data};
    assign last_word = (word_cnt == (n_words - 16'd1));
    assign word_end  = (state == DATA) && xfer && (byte_cnt == 2'd3);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LEN_HI;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        next_state = state;
        rx_ready   = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            LEN_HI: begin
                rx_ready = 1'b1;
                if (xfer) next_state = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    if (len_full == 16'd0) begin
                        next_state = CSUM;
                    end else if (len_full > MAX_N) begin
                        next_state = ERR;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (word_end && last_word) next_state = CSUM;
            end
            CSUM: begin
                rx_ready = 1'b1;
                if (xfer) next_state = (rx_data == csum) ? DONE : ERR;
            end
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: begin
                next_state = LEN_HI;
            end
        endcase
    end

    // Datapath: length capture, word assembly, checksum and write port
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt   <= 2'd0;
            word_cnt   <= 16'd0;
            n_words    <= 16'd0;
            csum       <= 8'h00;
            asm_reg    <= 32'd0;
            imem_we    <= 1'b0;
            imem_addr  <= ADDR_BASE;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (xfer) begin
                case (state)
                    LEN_HI: n_words <= {rx_data, 8'h00};
                    LEN_LO: n_words <= len_full;
                    DATA: begin
                        asm_reg  <= {asm_reg[23:0], rx_data};
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Strobe is registered, so the last word still writes after
                            // the FSM has moved on to CSUM.
                            imem_we    <= 1'b1;
                            imem_wdata <= {asm_reg[23:0], rx_data};
                            imem_addr  <= ADDR_BASE + {14'd0, word_cnt, 2'b00};
                            word_cnt   <= word_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
